// File: rtl/voxel_walk_ctrl.sv
// voxel_walk_ctrl: sequential DDA walker over a 32x32x32 occupancy grid.
// Accepts one ray, queries occupancy once per voxel, advances along the
// minimum-timer axis (several axes on ties) and reports a hit or miss record.
module voxel_walk_ctrl #(
  parameter int unsigned W         = 32,
  parameter int unsigned MAX_STEPS = 96
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  // Ray intake
  input  logic         i_ray_valid,
  output logic         o_ray_ready,
  input  logic [4:0]   i_ray_ix,
  input  logic [4:0]   i_ray_iy,
  input  logic [4:0]   i_ray_iz,
  input  logic         i_ray_sx,
  input  logic         i_ray_sy,
  input  logic         i_ray_sz,
  input  logic [W-1:0] i_ray_next_x,
  input  logic [W-1:0] i_ray_next_y,
  input  logic [W-1:0] i_ray_next_z,
  input  logic [W-1:0] i_ray_inc_x,
  input  logic [W-1:0] i_ray_inc_y,
  input  logic [W-1:0] i_ray_inc_z,
  // Occupancy memory
  output logic         o_mem_req_valid,
  input  logic         i_mem_req_ready,
  output logic [14:0]  o_mem_addr,
  input  logic         i_mem_rsp_valid,
  input  logic         i_mem_rsp_occ,
  // Result
  output logic         o_res_valid,
  input  logic         i_res_ready,
  output logic         o_res_hit,
  output logic [4:0]   o_res_ix,
  output logic [4:0]   o_res_iy,
  output logic [4:0]   o_res_iz,
  output logic [W-1:0] o_res_t,
  output logic [2:0]   o_res_face_id,
  output logic [6:0]   o_res_steps
);

  typedef enum logic [2:0] {StIdle, StQuery, StWait, StStep, StDone} state_e;

  localparam logic [6:0] StepLimit = 7'(MAX_STEPS);

  state_e       r_state;
  state_e       w_state_d;
  logic         r_ray_ready;

  logic [4:0]   r_ix;
  logic [4:0]   r_iy;
  logic [4:0]   r_iz;
  logic         r_sx;
  logic         r_sy;
  logic         r_sz;
  logic [W-1:0] r_next_x;
  logic [W-1:0] r_next_y;
  logic [W-1:0] r_next_z;
  logic [W-1:0] r_inc_x;
  logic [W-1:0] r_inc_y;
  logic [W-1:0] r_inc_z;
  logic [W-1:0] r_t;
  logic [2:0]   r_face;
  logic [6:0]   r_steps;
  logic         r_hit;

  logic         w_accept;
  logic [W-1:0] w_min_xy;
  logic [W-1:0] w_min;
  logic         w_mask_x;
  logic         w_mask_y;
  logic         w_mask_z;
  logic         w_edge_x;
  logic         w_edge_y;
  logic         w_edge_z;
  logic         w_exit;
  logic         w_budget;
  logic         w_advance;
  logic [2:0]   w_face;

  // Timer add that clamps at all-ones instead of wrapping.
  function automatic logic [W-1:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[W] ? {W{1'b1}} : s[W-1:0];
  endfunction

  // DDA step decision: minimum timer, tie mask, grid-exit and budget tests.
  assign w_min_xy = (r_next_x <= r_next_y) ? r_next_x : r_next_y;
  assign w_min    = (w_min_xy <= r_next_z) ? w_min_xy : r_next_z;
  assign w_mask_x = (r_next_x == w_min);
  assign w_mask_y = (r_next_y == w_min);
  assign w_mask_z = (r_next_z == w_min);
  assign w_edge_x = r_sx ? (r_ix == 5'd31) : (r_ix == 5'd0);
  assign w_edge_y = r_sy ? (r_iy == 5'd31) : (r_iy == 5'd0);
  assign w_edge_z = r_sz ? (r_iz == 5'd31) : (r_iz == 5'd0);
  assign w_exit   = (w_mask_x & w_edge_x) | (w_mask_y & w_edge_y) | (w_mask_z & w_edge_z);
  assign w_budget = (r_steps == StepLimit);
  assign w_advance = ~w_exit & ~w_budget;
  assign w_accept = (r_state == StIdle) & r_ray_ready & i_ray_valid;

  // Entry face of the next voxel: first masked axis in X, Y, Z order.
  always_comb begin
    w_face = 3'd7;
    if (w_mask_x)      w_face = r_sx ? 3'd0 : 3'd1;
    else if (w_mask_y) w_face = r_sy ? 3'd2 : 3'd3;
    else if (w_mask_z) w_face = r_sz ? 3'd4 : 3'd5;
  end

  // Next-state logic.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_d = StQuery;
      StQuery: if (i_mem_req_ready) w_state_d = StWait;
      StWait:  if (i_mem_rsp_valid) w_state_d = i_mem_rsp_occ ? StDone : StStep;
      StStep:  w_state_d = w_advance ? StQuery : StDone;
      StDone:  if (i_res_ready) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // State register; ray_ready is registered so it stays low through reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_ray_ready <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_ray_ready <= (w_state_d == StIdle);
    end
  end

  // Ray latch and per-step iteration state.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_ix     <= '0;
      r_iy     <= '0;
      r_iz     <= '0;
      r_sx     <= 1'b0;
      r_sy     <= 1'b0;
      r_sz     <= 1'b0;
      r_next_x <= '0;
      r_next_y <= '0;
      r_next_z <= '0;
      r_inc_x  <= '0;
      r_inc_y  <= '0;
      r_inc_z  <= '0;
      r_t      <= '0;
      r_face   <= '0;
      r_steps  <= '0;
      r_hit    <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_ix     <= i_ray_ix;
            r_iy     <= i_ray_iy;
            r_iz     <= i_ray_iz;
            r_sx     <= i_ray_sx;
            r_sy     <= i_ray_sy;
            r_sz     <= i_ray_sz;
            r_next_x <= i_ray_next_x;
            r_next_y <= i_ray_next_y;
            r_next_z <= i_ray_next_z;
            r_inc_x  <= i_ray_inc_x;
            r_inc_y  <= i_ray_inc_y;
            r_inc_z  <= i_ray_inc_z;
            r_t      <= '0;
            r_face   <= 3'd7;
            r_steps  <= '0;
          end
        end
        StWait: begin
          if (i_mem_rsp_valid) r_hit <= i_mem_rsp_occ;
        end
        StStep: begin
          if (w_advance) begin
            if (w_mask_x) begin
              r_ix     <= r_sx ? r_ix + 5'd1 : r_ix - 5'd1;
              r_next_x <= sat_add(r_next_x, r_inc_x);
            end
            if (w_mask_y) begin
              r_iy     <= r_sy ? r_iy + 5'd1 : r_iy - 5'd1;
              r_next_y <= sat_add(r_next_y, r_inc_y);
            end
            if (w_mask_z) begin
              r_iz     <= r_sz ? r_iz + 5'd1 : r_iz - 5'd1;
              r_next_z <= sat_add(r_next_z, r_inc_z);
            end
            r_t     <= w_min;
            r_face  <= w_face;
            r_steps <= r_steps + 7'd1;
          end else begin
            r_hit <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_ray_ready     = r_ray_ready;
  assign o_mem_req_valid = (r_state == StQuery);
  assign o_mem_addr      = {r_iz, r_iy, r_ix};
  assign o_res_valid     = (r_state == StDone);
  assign o_res_hit       = r_hit;
  assign o_res_ix        = r_ix;
  assign o_res_iy        = r_iy;
  assign o_res_iz        = r_iz;
  assign o_res_t         = r_t;
  assign o_res_face_id   = r_face;
  assign o_res_steps     = r_steps;

endmodule

// File: tb/tb_voxel_walk_ctrl.sv
// Testbench for voxel_walk_ctrl: directed scenarios plus randomized rays
// checked against a loop-based DDA reference model and an occupancy map.
`timescale 1ns/1ps
module tb_voxel_walk_ctrl;
  localparam int     TbMaxSteps = 4;
  localparam longint TMax       = 64'h0000_0000_FFFF_FFFF;

  typedef struct {
    int     ix, iy, iz;
    bit     sx, sy, sz;
    longint nx, ny, nz;
    longint cx, cy, cz;
  } ray_t;

  typedef struct {
    bit     hit;
    int     ix, iy, iz;
    longint t;
    int     face;
    int     steps;
  } res_t;

  logic        clk;
  logic        i_rst_n;
  logic        i_ray_valid;
  logic        o_ray_ready;
  logic [4:0]  i_ray_ix, i_ray_iy, i_ray_iz;
  logic        i_ray_sx, i_ray_sy, i_ray_sz;
  logic [31:0] i_ray_next_x, i_ray_next_y, i_ray_next_z;
  logic [31:0] i_ray_inc_x, i_ray_inc_y, i_ray_inc_z;
  logic        o_mem_req_valid;
  logic        i_mem_req_ready;
  logic [14:0] o_mem_addr;
  logic        i_mem_rsp_valid;
  logic        i_mem_rsp_occ;
  logic        o_res_valid;
  logic        i_res_ready;
  logic        o_res_hit;
  logic [4:0]  o_res_ix, o_res_iy, o_res_iz;
  logic [31:0] o_res_t;
  logic [2:0]  o_res_face_id;
  logic [6:0]  o_res_steps;

  int checks   = 0;
  int failures = 0;

  bit occ_map [0:32767];
  int addr_log[$];
  int exp_addr[$];
  int stall_left = 0;
  int rsp_lat    = 1;
  bit rand_stall = 0;

  voxel_walk_ctrl #(.W(32), .MAX_STEPS(TbMaxSteps)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n),
    .i_ray_valid(i_ray_valid), .o_ray_ready(o_ray_ready),
    .i_ray_ix(i_ray_ix), .i_ray_iy(i_ray_iy), .i_ray_iz(i_ray_iz),
    .i_ray_sx(i_ray_sx), .i_ray_sy(i_ray_sy), .i_ray_sz(i_ray_sz),
    .i_ray_next_x(i_ray_next_x), .i_ray_next_y(i_ray_next_y), .i_ray_next_z(i_ray_next_z),
    .i_ray_inc_x(i_ray_inc_x), .i_ray_inc_y(i_ray_inc_y), .i_ray_inc_z(i_ray_inc_z),
    .o_mem_req_valid(o_mem_req_valid), .i_mem_req_ready(i_mem_req_ready),
    .o_mem_addr(o_mem_addr), .i_mem_rsp_valid(i_mem_rsp_valid), .i_mem_rsp_occ(i_mem_rsp_occ),
    .o_res_valid(o_res_valid), .i_res_ready(i_res_ready), .o_res_hit(o_res_hit),
    .o_res_ix(o_res_ix), .o_res_iy(o_res_iy), .o_res_iz(o_res_iz),
    .o_res_t(o_res_t), .o_res_face_id(o_res_face_id), .o_res_steps(o_res_steps)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  // Occupancy memory: decides ready at negedge, answers rsp_lat cycles after accept.
  initial begin : mem_responder
    int rsp_cnt;
    bit rsp_occ;
    rsp_cnt = 0;
    rsp_occ = 1'b0;
    i_mem_req_ready = 1'b0;
    i_mem_rsp_valid = 1'b0;
    i_mem_rsp_occ   = 1'b0;
    forever begin
      @(negedge clk);
      i_mem_rsp_valid = 1'b0;
      if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          i_mem_rsp_valid = 1'b1;
          i_mem_rsp_occ   = rsp_occ;
        end
      end
      i_mem_req_ready = 1'b0;
      if (o_mem_req_valid) begin
        if (stall_left > 0) begin
          stall_left--;
        end else begin
          i_mem_req_ready = 1'b1;
          addr_log.push_back(int'(o_mem_addr));
          rsp_occ    = occ_map[int'(o_mem_addr)];
          rsp_cnt    = rsp_lat;
          stall_left = rand_stall ? int'($urandom_range(0, 3)) : 0;
        end
      end
    end
  end

  function automatic int addr_of(input int x, input int y, input int z);
    return z * 1024 + y * 32 + x;
  endfunction

  function automatic ray_t mk_ray(input int ix, input int iy, input int iz,
                                  input bit sx, input bit sy, input bit sz,
                                  input longint nx, input longint ny, input longint nz,
                                  input longint cx, input longint cy, input longint cz);
    ray_t r;
    r.ix = ix; r.iy = iy; r.iz = iz;
    r.sx = sx; r.sy = sy; r.sz = sz;
    r.nx = nx; r.ny = ny; r.nz = nz;
    r.cx = cx; r.cy = cy; r.cz = cz;
    return r;
  endfunction

  function automatic bit addr_match();
    if (addr_log.size() != exp_addr.size()) return 1'b0;
    foreach (addr_log[i]) if (addr_log[i] != exp_addr[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic clear_occ();
    foreach (occ_map[i]) occ_map[i] = 1'b0;
  endtask

  // Reference DDA walk over the occupancy map; fills exp_addr with the query order.
  task automatic model_walk(input ray_t r, output res_t e);
    int     idx[3];
    bit     s[3];
    longint nxt[3];
    longint inc[3];
    longint m;
    bit     ex;
    bit     first;
    int     a;
    idx[0] = r.ix; idx[1] = r.iy; idx[2] = r.iz;
    s[0] = r.sx;   s[1] = r.sy;   s[2] = r.sz;
    nxt[0] = r.nx; nxt[1] = r.ny; nxt[2] = r.nz;
    inc[0] = r.cx; inc[1] = r.cy; inc[2] = r.cz;
    e.hit = 1'b0; e.t = 0; e.face = 7; e.steps = 0;
    exp_addr.delete();
    for (int guard = 0; guard < 200; guard++) begin
      a = addr_of(idx[0], idx[1], idx[2]);
      exp_addr.push_back(a);
      if (occ_map[a]) begin
        e.hit = 1'b1;
        break;
      end
      m = nxt[0];
      if (nxt[1] < m) m = nxt[1];
      if (nxt[2] < m) m = nxt[2];
      ex = 1'b0;
      for (int k = 0; k < 3; k++)
        if (nxt[k] == m && ((s[k] && idx[k] == 31) || (!s[k] && idx[k] == 0))) ex = 1'b1;
      if (ex || e.steps == TbMaxSteps) break;
      first = 1'b1;
      for (int k = 0; k < 3; k++) begin
        if (nxt[k] == m) begin
          idx[k] = s[k] ? idx[k] + 1 : idx[k] - 1;
          nxt[k] = (nxt[k] + inc[k] > TMax) ? TMax : nxt[k] + inc[k];
          if (first) e.face = 2 * k + (s[k] ? 0 : 1);
          first = 1'b0;
        end
      end
      e.t = m;
      e.steps++;
    end
    e.ix = idx[0]; e.iy = idx[1]; e.iz = idx[2];
  endtask

  task automatic drive_ray(input ray_t r);
    i_ray_ix = 5'(r.ix); i_ray_iy = 5'(r.iy); i_ray_iz = 5'(r.iz);
    i_ray_sx = r.sx; i_ray_sy = r.sy; i_ray_sz = r.sz;
    i_ray_next_x = 32'(r.nx); i_ray_next_y = 32'(r.ny); i_ray_next_z = 32'(r.nz);
    i_ray_inc_x = 32'(r.cx); i_ray_inc_y = 32'(r.cy); i_ray_inc_z = 32'(r.cz);
  endtask

  task automatic scramble_ray();
    i_ray_ix = 5'($urandom); i_ray_iy = 5'($urandom); i_ray_iz = 5'($urandom);
    i_ray_sx = 1'($urandom); i_ray_sy = 1'($urandom); i_ray_sz = 1'($urandom);
    i_ray_next_x = $urandom; i_ray_next_y = $urandom; i_ray_next_z = $urandom;
    i_ray_inc_x = $urandom; i_ray_inc_y = $urandom; i_ray_inc_z = $urandom;
  endtask

  // Offers a ray once ready; returns at the negedge of the first busy cycle.
  task automatic send_ray(input ray_t r);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (o_ray_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL ray_ready_timeout got=0 want=1");
      return;
    end
    drive_ray(r);
    i_ray_valid = 1'b1;
    @(negedge clk);
    i_ray_valid = 1'b0;
    scramble_ray();
  endtask

  task automatic get_result(output res_t g, output int lat);
    bit seen;
    seen = 1'b0;
    lat  = 1;
    for (int i = 0; i < 1000; i++) begin
      if (o_res_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      lat++;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL result_timeout got res_valid=0 want=1");
    end
    g.hit = o_res_hit; g.ix = int'(o_res_ix); g.iy = int'(o_res_iy); g.iz = int'(o_res_iz);
    g.t = longint'(o_res_t); g.face = int'(o_res_face_id); g.steps = int'(o_res_steps);
  endtask

  task automatic consume();
    i_res_ready = 1'b1;
    @(negedge clk);
    i_res_ready = 1'b0;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (o_ray_ready !== 1'b0) begin
      failures++; $display("FAIL reset_ray_ready got=%b want=0", o_ray_ready);
    end
    checks++;
    if (o_mem_req_valid !== 1'b0 || o_res_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valids got=%b%b want=00", o_mem_req_valid, o_res_valid);
    end
    checks++;
    if (o_mem_addr !== 15'd0) begin
      failures++; $display("FAIL reset_mem_addr got=%0h want=0", o_mem_addr);
    end
    checks++;
    if ({o_res_hit, o_res_ix, o_res_iy, o_res_iz, o_res_t, o_res_face_id, o_res_steps} !== 58'd0) begin
      failures++; $display("FAIL reset_res_fields got=nonzero want=0");
    end
    i_rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (o_ray_ready !== 1'b1) begin
      failures++; $display("FAIL reset_release_ready got=%b want=1", o_ray_ready);
    end
  endtask

  task automatic test_origin_hit();
    res_t g;
    int   lat;
    clear_occ();
    occ_map[addr_of(3, 4, 5)] = 1'b1;
    addr_log.delete();
    send_ray(mk_ray(3, 4, 5, 1, 0, 1, 7, 9, 11, 1, 1, 1));
    get_result(g, lat);
    checks++;
    if (g.hit !== 1'b1 || g.ix != 3 || g.iy != 4 || g.iz != 5) begin
      failures++;
      $display("FAIL origin_voxel got=%0d/(%0d,%0d,%0d) want=1/(3,4,5)", g.hit, g.ix, g.iy, g.iz);
    end
    checks++;
    if (g.face != 7 || g.t != 0 || g.steps != 0) begin
      failures++;
      $display("FAIL origin_fts got=%0d/%0d/%0d want=7/0/0", g.face, g.t, g.steps);
    end
    checks++;
    if (lat != 3) begin
      failures++; $display("FAIL origin_latency got=%0d want=3", lat);
    end
    checks++;
    if (addr_log.size() != 1) begin
      failures++; $display("FAIL origin_queries got=%0d want=1", addr_log.size());
    end
    consume();
  endtask

  task automatic test_x_walk();
    res_t g;
    int   lat;
    clear_occ();
    occ_map[addr_of(3, 7, 7)] = 1'b1;
    addr_log.delete();
    exp_addr.delete();
    for (int i = 0; i < 4; i++) exp_addr.push_back(addr_of(i, 7, 7));
    send_ray(mk_ray(0, 7, 7, 1, 1, 1, 10, TMax, TMax, 10, 1, 1));
    get_result(g, lat);
    checks++;
    if (!addr_match()) begin
      failures++; $display("FAIL xwalk_addrs got=%0d queries want=4 (ix 0..3)", addr_log.size());
    end
    checks++;
    if (g.hit !== 1'b1 || g.ix != 3 || g.iy != 7 || g.iz != 7) begin
      failures++;
      $display("FAIL xwalk_voxel got=%0d/(%0d,%0d,%0d) want=1/(3,7,7)", g.hit, g.ix, g.iy, g.iz);
    end
    checks++;
    if (g.t != 30 || g.face != 0 || g.steps != 3) begin
      failures++;
      $display("FAIL xwalk_tfs got=%0d/%0d/%0d want=30/0/3", g.t, g.face, g.steps);
    end
    consume();
  endtask

  task automatic test_tie();
    res_t g;
    int   lat;
    clear_occ();
    occ_map[addr_of(11, 9, 0)] = 1'b1;
    addr_log.delete();
    exp_addr.delete();
    exp_addr.push_back(addr_of(10, 10, 0));
    exp_addr.push_back(addr_of(11, 9, 0));
    send_ray(mk_ray(10, 10, 0, 1, 0, 1, 5, 5, TMax, 8, 8, 1));
    get_result(g, lat);
    checks++;
    if (!addr_match()) begin
      failures++; $display("FAIL tie_addrs got=%0d queries want=2", addr_log.size());
    end
    checks++;
    if (g.hit !== 1'b1 || g.ix != 11 || g.iy != 9 || g.iz != 0 ||
        g.t != 5 || g.face != 0 || g.steps != 1) begin
      failures++;
      $display("FAIL tie_result got=%0d/(%0d,%0d,%0d)/t%0d/f%0d/s%0d want=1/(11,9,0)/t5/f0/s1",
               g.hit, g.ix, g.iy, g.iz, g.t, g.face, g.steps);
    end
    consume();
  endtask

  task automatic test_exit();
    res_t g;
    int   lat;
    clear_occ();
    for (int c = 0; c < 2; c++) begin
      addr_log.delete();
      if (c == 0) send_ray(mk_ray(31, 5, 5, 1, 1, 1, 4, 100, 100, 3, 3, 3));
      else        send_ray(mk_ray(0, 5, 5, 0, 1, 1, 4, 100, 100, 3, 3, 3));
      get_result(g, lat);
      checks++;
      if (g.hit !== 1'b0 || g.ix != (c == 0 ? 31 : 0) || g.t != 0 || g.steps != 0 ||
          g.face != 7 || addr_log.size() != 1) begin
        failures++;
        $display("FAIL exit_%0d got=%0d/ix%0d/t%0d/s%0d/f%0d/q%0d want=0/ix%0d/t0/s0/f7/q1", c,
                 g.hit, g.ix, g.t, g.steps, g.face, addr_log.size(), (c == 0 ? 31 : 0));
      end
      consume();
    end
  endtask

  task automatic test_budget();
    res_t g;
    int   lat;
    clear_occ();
    addr_log.delete();
    send_ray(mk_ray(5, 0, 5, 1, 1, 1, TMax, 1, TMax, 1, 1, 1));
    get_result(g, lat);
    checks++;
    if (g.hit !== 1'b0 || g.steps != TbMaxSteps || addr_log.size() != TbMaxSteps + 1) begin
      failures++;
      $display("FAIL budget_count got=%0d/s%0d/q%0d want=0/s4/q5", g.hit, g.steps, addr_log.size());
    end
    checks++;
    if (g.iy != 4 || g.t != 4 || g.face != 2) begin
      failures++; $display("FAIL budget_state got=iy%0d/t%0d/f%0d want=iy4/t4/f2", g.iy, g.t, g.face);
    end
    consume();
  endtask

  task automatic test_mem_stall();
    res_t g;
    int   lat;
    clear_occ();
    occ_map[addr_of(9, 8, 7)] = 1'b1;
    addr_log.delete();
    stall_left = 5;
    send_ray(mk_ray(9, 8, 7, 1, 1, 1, 3, 3, 3, 1, 1, 1));
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (o_mem_req_valid !== 1'b1 || int'(o_mem_addr) != addr_of(9, 8, 7)) begin
        failures++;
        $display("FAIL stall_addr_%0d got=%b/%0d want=1/%0d", i, o_mem_req_valid,
                 o_mem_addr, addr_of(9, 8, 7));
      end
      @(negedge clk);
    end
    get_result(g, lat);
    checks++;
    if (g.hit !== 1'b1 || addr_log.size() != 1) begin
      failures++; $display("FAIL stall_result got=%0d/q%0d want=1/q1", g.hit, addr_log.size());
    end
    consume();
  endtask

  task automatic test_res_hold();
    res_t g;
    int   lat;
    clear_occ();
    occ_map[addr_of(1, 2, 3)] = 1'b1;
    addr_log.delete();
    send_ray(mk_ray(1, 2, 3, 1, 1, 1, 6, 6, 6, 1, 1, 1));
    drive_ray(mk_ray(20, 20, 20, 1, 1, 1, 1, 2, 3, 1, 1, 1));
    i_ray_valid = 1'b1;
    get_result(g, lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (o_res_valid !== 1'b1 || o_ray_ready !== 1'b0 ||
          {o_res_hit, o_res_ix, o_res_iy, o_res_iz, o_res_face_id, o_res_steps} !==
          {1'b1, 5'd1, 5'd2, 5'd3, 3'd7, 7'd0} || o_res_t !== 32'd0) begin
        failures++;
        $display("FAIL hold_%0d got=v%b/r%b/(%0d,%0d,%0d) want=v1/r0/(1,2,3)", i,
                 o_res_valid, o_ray_ready, o_res_ix, o_res_iy, o_res_iz);
      end
    end
    i_ray_valid = 1'b0;
    consume();
    checks++;
    if (o_ray_ready !== 1'b1 || o_mem_req_valid !== 1'b0 || addr_log.size() != 1) begin
      failures++;
      $display("FAIL hold_release got=r%b/q%0d want=r1/q1", o_ray_ready, addr_log.size());
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    clear_occ();
    occ_map[addr_of(4, 4, 4)] = 1'b1;
    addr_log.delete();
    rsp_lat = 3;
    send_ray(mk_ray(4, 4, 4, 1, 1, 1, 2, 2, 2, 1, 1, 1));
    @(negedge clk);
    i_rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({o_ray_ready, o_mem_req_valid, o_res_valid, o_mem_addr, o_res_hit, o_res_ix, o_res_iy,
         o_res_iz, o_res_t, o_res_face_id, o_res_steps} !== 76'd0) begin
      failures++;
      $display("FAIL midreset_outputs got=r%b/q%b/v%b/a%0d want=all0", o_ray_ready,
               o_mem_req_valid, o_res_valid, o_mem_addr);
    end
    i_rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (o_res_valid || o_mem_req_valid) seen = 1'b1;
    end
    checks++;
    if (seen || o_ray_ready !== 1'b1) begin
      failures++;
      $display("FAIL midreset_late_rsp got=busy%0d/r%b want=busy0/r1", seen, o_ray_ready);
    end
    rsp_lat = 1;
  endtask

  task automatic test_random();
    ray_t r;
    res_t e;
    res_t g;
    int   lat;
    rand_stall = 1'b1;
    for (int n = 0; n < 60; n++) begin
      if (n % 10 == 0)
        foreach (occ_map[i]) occ_map[i] = ($urandom_range(0, 5) == 0);
      rsp_lat = int'($urandom_range(1, 3));
      r.ix = ($urandom_range(0, 2) == 0) ? 31 * int'($urandom_range(0, 1)) : int'($urandom_range(0, 31));
      r.iy = ($urandom_range(0, 2) == 0) ? 31 * int'($urandom_range(0, 1)) : int'($urandom_range(0, 31));
      r.iz = ($urandom_range(0, 2) == 0) ? 31 * int'($urandom_range(0, 1)) : int'($urandom_range(0, 31));
      r.sx = 1'($urandom); r.sy = 1'($urandom); r.sz = 1'($urandom);
      r.nx = ($urandom_range(0, 7) == 0) ? TMax - $urandom_range(0, 4) : longint'($urandom_range(0, 20));
      r.ny = ($urandom_range(0, 7) == 0) ? TMax - $urandom_range(0, 4) : longint'($urandom_range(0, 20));
      r.nz = ($urandom_range(0, 7) == 0) ? TMax - $urandom_range(0, 4) : longint'($urandom_range(0, 20));
      r.cx = longint'($urandom_range(0, 8));
      r.cy = longint'($urandom_range(0, 8));
      r.cz = longint'($urandom_range(0, 8));
      model_walk(r, e);
      addr_log.delete();
      send_ray(r);
      get_result(g, lat);
      checks++;
      if (g.hit !== e.hit || g.ix != e.ix || g.iy != e.iy || g.iz != e.iz) begin
        failures++;
        $display("FAIL rand%0d_voxel got=%0d/(%0d,%0d,%0d) want=%0d/(%0d,%0d,%0d)", n,
                 g.hit, g.ix, g.iy, g.iz, e.hit, e.ix, e.iy, e.iz);
      end
      checks++;
      if (g.t != e.t || g.face != e.face || g.steps != e.steps) begin
        failures++;
        $display("FAIL rand%0d_tfs got=%0d/%0d/%0d want=%0d/%0d/%0d", n,
                 g.t, g.face, g.steps, e.t, e.face, e.steps);
      end
      checks++;
      if (!addr_match()) begin
        failures++;
        $display("FAIL rand%0d_addrs got=%0d queries want=%0d", n, addr_log.size(), exp_addr.size());
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      consume();
    end
    rand_stall = 1'b0;
    rsp_lat    = 1;
  endtask

  initial begin
    i_rst_n     = 1'b0;
    i_ray_valid = 1'b0;
    i_res_ready = 1'b0;
    scramble_ray();
    test_reset();
    test_origin_hit();
    test_x_walk();
    test_tie();
    test_exit();
    test_budget();
    test_mem_stall();
    test_res_hold();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/voxel_walk_ctrl.md
# voxel_walk_ctrl

Sequential DDA traversal controller for the 32×32×32 voxel raytracer. It accepts one initialized ray (start voxel, step signs, initial axis timers, timer increments), then walks the grid voxel by voxel. For each voxel it queries the occupancy memory, and when a voxel does not hit it performs one DDA step: minimum-timer axis selection, index and timer update, and face encoding. It returns either a hit record or a miss record. It is the driving and consuming end of the per-voxel step interface, and owns the iteration state that the stepping datapath treats as inputs.

## Interface
- W, 32: timer/increment width (unsigned fixed-point)
- MAX_STEPS, 96: step budget per ray; 1..127
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- ray_valid  in  1  ray offered
- ray_ready  out  1  controller idle, ray accepted on valid&ready
- ray_ix/ray_iy/ray_iz  in  5 each  start voxel
- ray_sx/ray_sy/ray_sz  in  1 each  1 = +1 step, 0 = −1 step
- ray_next_x/y/z  in  W each  initial axis timers
- ray_inc_x/y/z  in  W each  timer increments
- mem_req_valid  out  1  occupancy query valid
- mem_req_ready  in  1  memory accepts query
- mem_addr  out  15  {iz,iy,ix}
- mem_rsp_valid  in  1  occupancy response valid
- mem_rsp_occ  in  1  1 = voxel occupied
- res_valid  out  1  result valid
- res_ready  in  1  result consumed
- res_hit  out  1  1 = hit, 0 = miss
- res_ix/res_iy/res_iz  out  5 each  hit voxel, or last in-grid voxel on miss
- res_t  out  W  entry timer of the reported voxel
- res_face_id  out  3  0=X+,1=X−,2=Y+,3=Y−,4=Z+,5=Z−,7=origin voxel (no face crossed)
- res_steps  out  7  steps taken

## Operation
- States: IDLE, QUERY, WAIT, STEP, DONE.
- IDLE: ray_ready=1. On valid&ready, latch all ray fields, then set t=0, face=7, steps=0, and go to QUERY.
- QUERY: mem_req_valid=1, with mem_addr from the current indices. mem_addr stays stable until mem_req_ready. On accept, go to WAIT.
- WAIT: wait for mem_rsp_valid. mem_rsp_valid is ignored in every other state.
  - occ=1 → DONE with hit=1.
  - occ=0 → STEP.
- STEP, one cycle:
  - m = min(next_x, next_y, next_z). The step mask has a bit set for every axis whose timer equals m, so ties step multiple axes.
  - Exit: if any masked axis has (s=1 and idx=31) or (s=0 and idx=0), go to DONE with hit=0. Indices, t and face are unchanged.
  - Step limit: otherwise, if steps == MAX_STEPS, go to DONE with hit=0, state unchanged.
  - Otherwise:
    - Masked indices move ±1.
    - Masked timers get += inc, saturating at 2^W−1.
    - t = m.
    - face = primary axis (priority X > Y > Z among masked) with its sign.
    - steps += 1.
    - Go to QUERY.
- DONE: res_valid=1, with res_* driven from registered state. On res_ready, go to IDLE.
- res_* hold their values outside DONE, but are only valid while res_valid=1.

## Timing
- Reset (rst_n=0 sampled at an edge):
  - state=IDLE.
  - ray_ready, mem_req_valid and res_valid are 0, and all other outputs are 0.
  - ray_ready is registered; it rises on the first edge with rst_n=1.
- Reset mid-ray aborts with no result. A response arriving after reset is ignored.
- Zero-wait memory (req_ready=1, response one cycle after accept) costs 3 cycles per voxel: QUERY, WAIT, STEP.
- Origin hit: accept at edge 0, QUERY in cycle 1, WAIT in cycle 2 (response), res_valid in cycle 3.
- res_ready high in the first DONE cycle gives ray_ready=1 in the next cycle. Back-to-back rays are therefore separated by ≥1 IDLE cycle.
- ray_valid while busy is not accepted. Ray inputs are sampled only on the accept edge.
- Memory back-pressure or response delay stalls the controller indefinitely, with no timeout.

## Test plan
- Origin hit: ray at (3,4,5), first response occ=1 → hit=1, (3,4,5), face=7, t=0, steps=0, res_valid 3 cycles after accept.
- X walk: start (0,7,7), sx=1, next_x=10, inc_x=10, next_y=next_z=2^W−1; occ=1 only at ix=3 → addresses ix=0,1,2,3; hit at (3,7,7), t=30, face=0, steps=3.
- Tie: start (10,10,0), sx=1, sy=0, next_x=next_y=5, inc 8 each, next_z=2^W−1; occ at (11,9,0) → two queries only; hit with t=5, face=0, steps=1; timers then 13/13.
- Exit: start ix=31, sx=1, next_x=4 (minimum), all empty → hit=0, res_ix=31, t=0, steps=0, one query. Mirror case: ix=0, sx=0 → same result.
- Budget: MAX_STEPS=4, y-only walk, all empty → hit=0, steps=4, five queries.
- Handshakes and reset:
  - Hold mem_req_ready=0 for 5 cycles → mem_addr stable.
  - Hold res_ready=0 → result stable, and ray_valid is ignored.
  - rst_n=0 for one cycle in WAIT → all outputs 0, and a late mem_rsp_valid causes no result.
